// File: rtl/lift_scan_controller.sv
// Lift controller using SCAN (elevator) ordering. Requests are latched into a
// pending mask. The car keeps sweeping in one direction while requests remain
// ahead of it, and reverses only when none are left ahead. Every output comes
// from a register, and emergency_stop overrides every state.
module lift_scan_controller #(
  parameter int  NUM_FLOORS    = 8,
  parameter int  TRAVEL_CYCLES = 4,
  parameter int  DOOR_CYCLES   = 3,
  localparam int FW            = ($clog2(NUM_FLOORS) < 1) ? 1 : $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] floor_req,
  input  logic                  emergency_stop,
  output logic                  c_up,
  output logic                  c_down,
  output logic                  motor_stop,
  output logic                  door_open,
  output logic [FW-1:0]         current_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up
);

  localparam int TCW = ($clog2(TRAVEL_CYCLES) < 1) ? 1 : $clog2(TRAVEL_CYCLES);
  localparam int DCW = ($clog2(DOOR_CYCLES) < 1) ? 1 : $clog2(DOOR_CYCLES);
  localparam logic [TCW-1:0] TRAVEL_LAST = TCW'(TRAVEL_CYCLES - 1);
  localparam logic [DCW-1:0] DOOR_LAST   = DCW'(DOOR_CYCLES - 1);
  localparam logic [FW-1:0]  TOP_FLOOR   = FW'(NUM_FLOORS - 1);
  localparam logic [FW-1:0]  BOTTOM_FLOOR = {FW{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MOVE_UP   = 3'd1,
    S_MOVE_DOWN = 3'd2,
    S_DOOR      = 3'd3,
    S_EMERGENCY = 3'd4
  } state_t;

  // Mask of floors strictly above the given floor.
  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FW-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = {NUM_FLOORS{1'b0}};
    for (int i = 0; i < NUM_FLOORS; i++) begin
      m[i] = (i > int'(f));
    end
    return m;
  endfunction

  // Mask of floors strictly below the given floor.
  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FW-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = {NUM_FLOORS{1'b0}};
    for (int i = 0; i < NUM_FLOORS; i++) begin
      m[i] = (i < int'(f));
    end
    return m;
  endfunction

  // One-hot bit for a floor, used to clear the request being served.
  function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FW-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = {NUM_FLOORS{1'b0}};
    for (int i = 0; i < NUM_FLOORS; i++) begin
      m[i] = (i == int'(f));
    end
    return m;
  endfunction

  state_t                state_r, state_s, scan_state_s;
  logic [FW-1:0]         floor_r, floor_s;
  logic [NUM_FLOORS-1:0] pending_r, pending_s, req_s;
  logic                  dir_up_r, dir_up_s, scan_dir_s;
  logic [TCW-1:0]        travel_cnt_r, travel_cnt_s;
  logic [DCW-1:0]        door_cnt_r, door_cnt_s;
  logic                  above_s, below_s;
  logic                  c_up_r, c_down_r, motor_stop_r, door_open_r;

  // A request arriving on the same edge a floor is served counts as served,
  // so the serving checks look at pending and the new request together.
  assign req_s   = pending_r | floor_req;
  assign above_s = |(pending_r & above_mask(floor_r));
  assign below_s = |(pending_r & below_mask(floor_r));

  // SCAN choice from a standstill: keep the sweep direction while work lies
  // ahead, otherwise reverse, otherwise rest.
  always_comb begin
    scan_state_s = S_IDLE;
    scan_dir_s   = dir_up_r;
    if (dir_up_r) begin
      if (above_s) begin
        scan_state_s = S_MOVE_UP;
      end else if (below_s) begin
        scan_state_s = S_MOVE_DOWN;
        scan_dir_s   = 1'b0;
      end else begin
        scan_state_s = S_IDLE;
      end
    end else begin
      if (below_s) begin
        scan_state_s = S_MOVE_DOWN;
      end else if (above_s) begin
        scan_state_s = S_MOVE_UP;
        scan_dir_s   = 1'b1;
      end else begin
        scan_state_s = S_IDLE;
      end
    end
  end

  // Next-state logic for the car: state, position, timers and request mask.
  always_comb begin
    state_s      = state_r;
    floor_s      = floor_r;
    pending_s    = req_s;
    dir_up_s     = dir_up_r;
    travel_cnt_s = travel_cnt_r;
    door_cnt_s   = door_cnt_r;
    if (emergency_stop) begin
      // Position and requests are held; any partial transit is forgotten.
      state_s      = S_EMERGENCY;
      travel_cnt_s = {TCW{1'b0}};
      door_cnt_s   = {DCW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_s[floor_r]) begin
            pending_s  = req_s & ~floor_bit(floor_r);
            state_s    = S_DOOR;
            door_cnt_s = {DCW{1'b0}};
          end else begin
            state_s      = scan_state_s;
            dir_up_s     = scan_dir_s;
            travel_cnt_s = {TCW{1'b0}};
          end
        end
        S_MOVE_UP: begin
          if (travel_cnt_r == TRAVEL_LAST) begin
            travel_cnt_s = {TCW{1'b0}};
            floor_s      = (floor_r == TOP_FLOOR) ? floor_r : floor_r + 1'b1;
            if (req_s[floor_s]) begin
              pending_s  = req_s & ~floor_bit(floor_s);
              state_s    = S_DOOR;
              door_cnt_s = {DCW{1'b0}};
            end else if (|(pending_r & above_mask(floor_s))) begin
              state_s = S_MOVE_UP;
            end else begin
              state_s = S_IDLE;
            end
          end else begin
            travel_cnt_s = travel_cnt_r + 1'b1;
          end
        end
        S_MOVE_DOWN: begin
          if (travel_cnt_r == TRAVEL_LAST) begin
            travel_cnt_s = {TCW{1'b0}};
            floor_s      = (floor_r == BOTTOM_FLOOR) ? floor_r : floor_r - 1'b1;
            if (req_s[floor_s]) begin
              pending_s  = req_s & ~floor_bit(floor_s);
              state_s    = S_DOOR;
              door_cnt_s = {DCW{1'b0}};
            end else if (|(pending_r & below_mask(floor_s))) begin
              state_s = S_MOVE_DOWN;
            end else begin
              state_s = S_IDLE;
            end
          end else begin
            travel_cnt_s = travel_cnt_r + 1'b1;
          end
        end
        S_DOOR: begin
          if (req_s[floor_r]) begin
            // Someone pressed this floor again: serve it and hold the door.
            pending_s  = req_s & ~floor_bit(floor_r);
            door_cnt_s = {DCW{1'b0}};
          end else if (door_cnt_r == DOOR_LAST) begin
            door_cnt_s   = {DCW{1'b0}};
            state_s      = scan_state_s;
            dir_up_s     = scan_dir_s;
            travel_cnt_s = {TCW{1'b0}};
          end else begin
            door_cnt_s = door_cnt_r + 1'b1;
          end
        end
        S_EMERGENCY: begin
          state_s      = S_IDLE;
          travel_cnt_s = {TCW{1'b0}};
        end
        default: begin
          state_s      = S_IDLE;
          travel_cnt_s = {TCW{1'b0}};
          door_cnt_s   = {DCW{1'b0}};
        end
      endcase
    end
  end

  // State registers plus output registers decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= S_IDLE;
      floor_r      <= {FW{1'b0}};
      pending_r    <= {NUM_FLOORS{1'b0}};
      dir_up_r     <= 1'b1;
      travel_cnt_r <= {TCW{1'b0}};
      door_cnt_r   <= {DCW{1'b0}};
      c_up_r       <= 1'b0;
      c_down_r     <= 1'b0;
      motor_stop_r <= 1'b1;
      door_open_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      floor_r      <= floor_s;
      pending_r    <= pending_s;
      dir_up_r     <= dir_up_s;
      travel_cnt_r <= travel_cnt_s;
      door_cnt_r   <= door_cnt_s;
      c_up_r       <= (state_s == S_MOVE_UP);
      c_down_r     <= (state_s == S_MOVE_DOWN);
      motor_stop_r <= ~((state_s == S_MOVE_UP) | (state_s == S_MOVE_DOWN));
      door_open_r  <= (state_s == S_DOOR);
    end
  end

  assign c_up          = c_up_r;
  assign c_down        = c_down_r;
  assign motor_stop    = motor_stop_r;
  assign door_open     = door_open_r;
  assign current_floor = floor_r;
  assign pending       = pending_r;
  assign dir_up        = dir_up_r;

endmodule

// File: tb/tb_lift_scan_controller.sv
// Scoreboard bench for lift_scan_controller (8 floors, 4-cycle travel,
// 3-cycle door). Directed stimulus pushes hand-computed snapshots tagged with
// the cycle they are due; a monitor on the falling edge compares them.
module tb_lift_scan_controller;

  logic       clk;
  logic       reset;
  logic [7:0] floor_req;
  logic       emergency_stop;
  logic       c_up, c_down, motor_stop, door_open, dir_up;
  logic [2:0] current_floor;
  logic [7:0] pending;

  // {c_up, c_down, motor_stop, door_open}
  localparam logic [3:0] MD_STOP = 4'b0010;
  localparam logic [3:0] MD_UP   = 4'b1000;
  localparam logic [3:0] MD_DN   = 4'b0100;
  localparam logic [3:0] MD_DOOR = 4'b0011;

  typedef struct {
    int         at;
    string      name;
    logic [15:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   base = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  lift_scan_controller #(
    .NUM_FLOORS   (8),
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES  (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .floor_req     (floor_req),
    .emergency_stop(emergency_stop),
    .c_up          (c_up),
    .c_down        (c_down),
    .motor_stop    (motor_stop),
    .door_open     (door_open),
    .current_floor (current_floor),
    .pending       (pending),
    .dir_up        (dir_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter: value N after the N-th rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Monitor: compare every snapshot due at this cycle.
  initial begin
    logic [15:0] obs;
    forever begin
      @(negedge clk);
      obs = {c_up, c_down, motor_stop, door_open, dir_up, current_floor, pending};
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
        if (sb_q[i].at == cyc) begin
          chk_cnt = chk_cnt + 1;
          if (obs === sb_q[i].val) begin
            pass_cnt = pass_cnt + 1;
          end else begin
            $display("FAIL %s @cyc %0d: got up/dn/stop/door=%b dir_up=%b floor=%0d pending=%h, expected %b %b %0d %h",
                     sb_q[i].name, cyc, obs[15:12], obs[11], obs[10:8], obs[7:0],
                     sb_q[i].val[15:12], sb_q[i].val[11], sb_q[i].val[10:8], sb_q[i].val[7:0]);
          end
          sb_q.delete(i);
        end else if (sb_q[i].at < cyc) begin
          chk_cnt = chk_cnt + 1;
          $display("FAIL %s: snapshot for cycle %0d never sampled (now %0d)", sb_q[i].name, sb_q[i].at, cyc);
          sb_q.delete(i);
        end
      end
    end
  end

  task automatic expect_at(input int d, input string nm, input logic [3:0] md,
                           input logic du, input logic [2:0] fl, input logic [7:0] pd);
    exp_t e;
    e.at   = base + d;
    e.name = nm;
    e.val  = {md, du, fl, pd};
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rel(input int k);
    while (cyc < base + k) step();
  endtask

  task automatic pulse_req(input logic [7:0] r);
    floor_req = r;
    step();
    floor_req = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    reset = 1'b1;
    floor_req = 8'h00;
    emergency_stop = 1'b0;
    repeat (3) step();

    // Reset state.
    base = cyc;
    expect_at(0, "reset_state", MD_STOP, 1'b1, 3'd0, 8'h00);
    reset = 1'b0;
    wait_rel(1);

    // Single request to floor 3 from floor 0.
    base = cyc;
    expect_at(1,  "a_latch",    MD_STOP, 1'b1, 3'd0, 8'h08);
    expect_at(2,  "a_start_up", MD_UP,   1'b1, 3'd0, 8'h08);
    expect_at(5,  "a_floor0",   MD_UP,   1'b1, 3'd0, 8'h08);
    expect_at(6,  "a_floor1",   MD_UP,   1'b1, 3'd1, 8'h08);
    expect_at(10, "a_floor2",   MD_UP,   1'b1, 3'd2, 8'h08);
    expect_at(14, "a_door3",    MD_DOOR, 1'b1, 3'd3, 8'h00);
    expect_at(16, "a_door3_end", MD_DOOR, 1'b1, 3'd3, 8'h00);
    expect_at(17, "a_idle",     MD_STOP, 1'b1, 3'd3, 8'h00);
    pulse_req(8'h08);
    wait_rel(18);

    // SCAN: going up from 3 with requests at 6 and 1.
    base = cyc;
    expect_at(1,  "b_latch6",   MD_STOP, 1'b1, 3'd3, 8'h40);
    expect_at(2,  "b_up",       MD_UP,   1'b1, 3'd3, 8'h40);
    expect_at(4,  "b_latch1",   MD_UP,   1'b1, 3'd3, 8'h42);
    expect_at(14, "b_door6",    MD_DOOR, 1'b1, 3'd6, 8'h02);
    expect_at(17, "b_reverse",  MD_DN,   1'b0, 3'd6, 8'h02);
    expect_at(37, "b_door1",    MD_DOOR, 1'b0, 3'd1, 8'h00);
    expect_at(40, "b_idle",     MD_STOP, 1'b0, 3'd1, 8'h00);
    pulse_req(8'h40);
    wait_rel(3);
    pulse_req(8'h02);
    wait_rel(41);

    // Go to floor 2, then same-floor request and door re-request.
    base = cyc;
    expect_at(1,  "c_latch2",   MD_STOP, 1'b0, 3'd1, 8'h04);
    expect_at(2,  "c_flip_up",  MD_UP,   1'b1, 3'd1, 8'h04);
    expect_at(6,  "c_door2",    MD_DOOR, 1'b1, 3'd2, 8'h00);
    expect_at(9,  "c_idle2",    MD_STOP, 1'b1, 3'd2, 8'h00);
    expect_at(10, "c_same_floor_door", MD_DOOR, 1'b1, 3'd2, 8'h00);
    expect_at(11, "c_door_hold", MD_DOOR, 1'b1, 3'd2, 8'h00);
    expect_at(14, "c_door_restart", MD_DOOR, 1'b1, 3'd2, 8'h00);
    expect_at(15, "c_door_close", MD_STOP, 1'b1, 3'd2, 8'h00);
    pulse_req(8'h04);
    wait_rel(9);
    pulse_req(8'h04);
    wait_rel(11);
    pulse_req(8'h04);
    wait_rel(16);

    // Emergency stop mid-transit, request latched while stopped.
    base = cyc;
    expect_at(1,  "d_latch4",   MD_STOP, 1'b1, 3'd2, 8'h10);
    expect_at(2,  "d_up",       MD_UP,   1'b1, 3'd2, 8'h10);
    expect_at(4,  "d_mid",      MD_UP,   1'b1, 3'd2, 8'h10);
    expect_at(5,  "d_estop",    MD_STOP, 1'b1, 3'd2, 8'h10);
    expect_at(6,  "d_estop_latch", MD_STOP, 1'b1, 3'd2, 8'h11);
    expect_at(8,  "d_release_idle", MD_STOP, 1'b1, 3'd2, 8'h11);
    expect_at(9,  "d_resume",   MD_UP,   1'b1, 3'd2, 8'h11);
    expect_at(12, "d_full_transit", MD_UP, 1'b1, 3'd2, 8'h11);
    expect_at(13, "d_floor3",   MD_UP,   1'b1, 3'd3, 8'h11);
    expect_at(17, "d_door4",    MD_DOOR, 1'b1, 3'd4, 8'h01);
    expect_at(20, "d_reverse",  MD_DN,   1'b0, 3'd4, 8'h01);
    expect_at(36, "d_door0",    MD_DOOR, 1'b0, 3'd0, 8'h00);
    expect_at(39, "d_idle0",    MD_STOP, 1'b0, 3'd0, 8'h00);
    pulse_req(8'h10);
    wait_rel(4);
    emergency_stop = 1'b1;
    wait_rel(5);
    pulse_req(8'h01);
    wait_rel(7);
    emergency_stop = 1'b0;
    wait_rel(40);

    // Bottom and top boundaries, request on the arrival edge.
    base = cyc;
    expect_at(1,  "e_bottom_door", MD_DOOR, 1'b0, 3'd0, 8'h00);
    expect_at(3,  "e_bottom_door_end", MD_DOOR, 1'b0, 3'd0, 8'h00);
    expect_at(4,  "e_bottom_idle", MD_STOP, 1'b0, 3'd0, 8'h00);
    expect_at(5,  "e_latch7",   MD_STOP, 1'b0, 3'd0, 8'h80);
    expect_at(6,  "e_up",       MD_UP,   1'b1, 3'd0, 8'h80);
    expect_at(33, "e_floor6",   MD_UP,   1'b1, 3'd6, 8'h80);
    expect_at(34, "e_arrive7_clear", MD_DOOR, 1'b1, 3'd7, 8'h00);
    expect_at(36, "e_door7",    MD_DOOR, 1'b1, 3'd7, 8'h00);
    expect_at(37, "e_single_stop", MD_STOP, 1'b1, 3'd7, 8'h00);
    expect_at(38, "e_stay_top", MD_STOP, 1'b1, 3'd7, 8'h00);
    expect_at(39, "e_top_door", MD_DOOR, 1'b1, 3'd7, 8'h00);
    expect_at(42, "e_top_idle", MD_STOP, 1'b1, 3'd7, 8'h00);
    pulse_req(8'h01);
    wait_rel(4);
    pulse_req(8'h80);
    wait_rel(33);
    pulse_req(8'h80);
    wait_rel(38);
    pulse_req(8'h80);
    wait_rel(43);

    // Asynchronous reset in the middle of a downward transit.
    base = cyc;
    expect_at(1,  "f_latch0",   MD_STOP, 1'b1, 3'd7, 8'h01);
    expect_at(2,  "f_down",     MD_DN,   1'b0, 3'd7, 8'h01);
    expect_at(6,  "f_floor6",   MD_DN,   1'b0, 3'd6, 8'h01);
    expect_at(7,  "f_reset_async", MD_STOP, 1'b1, 3'd0, 8'h00);
    expect_at(10, "f_after_reset", MD_STOP, 1'b1, 3'd0, 8'h00);
    pulse_req(8'h01);
    wait_rel(7);
    reset = 1'b1;
    wait_rel(9);
    reset = 1'b0;
    wait_rel(11);

    guard = 0;
    while (sb_q.size() != 0 && guard < 20) begin
      step();
      guard = guard + 1;
    end
    while (sb_q.size() != 0) begin
      chk_cnt = chk_cnt + 1;
      $display("FAIL %s: snapshot for cycle %0d still outstanding", sb_q[0].name, sb_q[0].at);
      sb_q.delete(0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/lift_scan_controller.md
LIFT_SCAN_CONTROLLER -- requirements
Module: lift_scan_controller

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 8: number of floors served, range 2..16.
REQ-002 SHALL have parameter TRAVEL_CYCLES, default 4: clock cycles to move one floor, ≥1.
REQ-003 SHALL have parameter DOOR_CYCLES, default 3: clock cycles the door stays open per stop, ≥1.
REQ-004 SHALL use derived width FW = clog2(NUM_FLOORS), minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port floor_req, input, NUM_FLOORS bits: one-hot or multi-hot request pulses or levels, one bit per floor.
REQ-008 SHALL have port emergency_stop, input, 1 bit: level; highest priority.
REQ-009 SHALL have port c_up, output, 1 bit: motor driving up.
REQ-010 SHALL have port c_down, output, 1 bit: motor driving down.
REQ-011 SHALL have port motor_stop, output, 1 bit: motor not driving.
REQ-012 SHALL have port door_open, output, 1 bit: door open at current_floor.
REQ-013 SHALL have port current_floor, output, FW bits: floor the car is at, or last floor passed.
REQ-014 SHALL have port pending, output, NUM_FLOORS bits: latched, not-yet-served requests.
REQ-015 SHALL have port dir_up, output, 1 bit: sweep direction; 1 = up.

Function
REQ-016 SHALL keep state in IDLE, MOVE_UP, MOVE_DOWN, DOOR or EMERGENCY, with every output registered or decoded from registered state (Moore).
REQ-017 SHALL set pending <= pending | floor_req on every clock edge in every state, including EMERGENCY.
  - Exception: the bit of a floor being served that edge is cleared, and clear wins over a same-cycle request for that floor.
REQ-018 SHALL decode outputs as follows:
  - c_up=1 only in MOVE_UP; c_down=1 only in MOVE_DOWN.
  - motor_stop = ~(c_up|c_down).
  - door_open=1 only in DOOR.
  - c_up and c_down SHALL never both be 1.
REQ-019 SHALL, in IDLE with pending[current_floor]=1, clear that bit and enter DOOR.
REQ-020 SHALL, in IDLE otherwise, move toward pending requests:
  - Requests only in dir_up direction: move in that direction.
  - Requests only in the other direction: flip dir_up and move that way.
  - No pending: stay IDLE.
REQ-021 SHALL, in MOVE_UP/MOVE_DOWN, count travel cycles from 0 to TRAVEL_CYCLES-1, and on that edge:
  - Step current_floor by ±1.
  - Reset the counter.
  - If pending[new floor]=1: clear it and enter DOOR.
  - Otherwise keep moving.
REQ-022 SHALL implement SCAN order: after DOOR expires, continue in dir_up if any pending lies strictly beyond current_floor in that direction; else reverse if any pending lies the other way; else IDLE.
REQ-023 SHALL hold DOOR for exactly DOOR_CYCLES cycles.
  - A new request for current_floor during DOOR clears immediately and restarts the door timer.
REQ-024 SHALL never step below floor 0 or above NUM_FLOORS-1; floor_req bits ≥ NUM_FLOORS do not exist.
REQ-025 SHALL, on emergency_stop=1, enter EMERGENCY on the next edge from any state:
  - motor_stop=1, door_open=0.
  - Travel counter cleared; current_floor and pending held.
REQ-026 SHALL, when emergency_stop is released, go EMERGENCY -> IDLE on the next edge.
  - Service resumes per REQ-019/020 with a full TRAVEL_CYCLES for any partially travelled floor.

Reset
REQ-027 SHALL, while reset=1, asynchronously force:
  - state=IDLE, current_floor=0, pending=0, dir_up=1, counters=0.
  - c_up=0, c_down=0, motor_stop=1, door_open=0.
REQ-028 SHALL, on reset asserted mid-travel or mid-door, discard all pending requests and return to floor 0 without any motor output glitch.

Verification (defaults: NUM_FLOORS=8, TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-029 SHALL cover: reset, 1-cycle pulse floor_req=8'h08 -> pending[3]=1 next edge, c_up=1 one edge later, current_floor 1,2,3 every 4 cycles, door_open=1 for 3 cycles at floor 3, then IDLE with pending=0.
REQ-030 SHALL cover: at floor 3 moving up, requests for floors 1 and 6 -> stops at 6 first, then reverses (dir_up=0) and stops at 1.
REQ-031 SHALL cover: IDLE at floor 2 with floor_req[2] -> door_open=1 next edge with no motor motion; re-request during DOOR -> door open 3 cycles from the re-request.
REQ-032 SHALL cover: emergency_stop=1 two cycles into a floor transit -> motor_stop=1 next edge, current_floor unchanged, pending kept; release -> after 1 IDLE cycle, full 4-cycle transit to the next floor.
REQ-033 SHALL cover: request on the arrival edge of the same floor -> bit cleared, single 3-cycle door stop; request to floor 7 at top and to floor 0 at bottom -> no step out of range.
REQ-034 SHALL cover: reset asserted mid-transit -> all outputs at reset values immediately, without waiting for a clock edge.
